// File: rtl/inv_sbox_layer.sv
// Iterative inverse ASCON 5-bit S-box layer over a 320-bit state, LANES columns per cycle.
module inv_sbox_layer #(
  parameter int unsigned LANES = 8
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned N  = 64 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Reject lane counts that do not tile the 64 columns evenly.
  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
      $error("inv_sbox_layer: LANES must be a power of two in 1..64");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [319:0]  work_q, work_d;
  logic [319:0]  run_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Inverse of the ASCON forward S-box, column value x0 is the MSB.
  function automatic logic [4:0] inv5(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h14; 5'h01: y = 5'h1a; 5'h02: y = 5'h07; 5'h03: y = 5'h0d;
      5'h04: y = 5'h00; 5'h05: y = 5'h09; 5'h06: y = 5'h0e; 5'h07: y = 5'h12;
      5'h08: y = 5'h0a; 5'h09: y = 5'h06; 5'h0a: y = 5'h1d; 5'h0b: y = 5'h01;
      5'h0c: y = 5'h19; 5'h0d: y = 5'h15; 5'h0e: y = 5'h13; 5'h0f: y = 5'h1e;
      5'h10: y = 5'h18; 5'h11: y = 5'h16; 5'h12: y = 5'h0b; 5'h13: y = 5'h11;
      5'h14: y = 5'h03; 5'h15: y = 5'h05; 5'h16: y = 5'h1c; 5'h17: y = 5'h1f;
      5'h18: y = 5'h17; 5'h19: y = 5'h1b; 5'h1a: y = 5'h04; 5'h1b: y = 5'h08;
      5'h1c: y = 5'h0f; 5'h1d: y = 5'h0c; 5'h1e: y = 5'h10; default: y = 5'h02;
    endcase
    return y;
  endfunction

  // Working state with the current chunk of columns replaced by their inverses.
  always_comb begin
    run_d = work_q;
    for (int l = 0; l < int'(LANES); l++) begin : g_lane
      logic [8:0] idx;
      logic [4:0] col;
      idx = 9'(9'(cnt_q) * 9'(LANES)) + 9'(l);
      col = {work_q[9'(256) + idx], work_q[9'(192) + idx], work_q[9'(128) + idx],
             work_q[9'(64) + idx], work_q[idx]};
      col = inv5(col);
      run_d[9'(256) + idx] = col[4];
      run_d[9'(192) + idx] = col[3];
      run_d[9'(128) + idx] = col[2];
      run_d[9'(64) + idx]  = col[1];
      run_d[idx]           = col[0];
    end
  end

  // Next-state, counter, datapath and registered Moore output decode.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    case (fsm_q)
      S_IDLE: begin
        if (start_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = S_RUN;
        end
      end
      S_RUN: begin
        work_d = run_d;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d = '0;
          fsm_d = S_DONE;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      S_DONE: begin
        if (start_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = S_RUN;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
    busy_d = (fsm_d == S_RUN);
    done_d = (fsm_d == S_DONE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q  <= S_IDLE;
      cnt_q  <= '0;
      work_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign state_o = work_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_inv_sbox_layer.sv
// Self-checking bench for inv_sbox_layer at LANES = 8, 1 and 64 with a done-driven scoreboard.
module tb_inv_sbox_layer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start [3];
  logic [319:0] sin   [3];
  logic [319:0] sout  [3];
  logic         busy  [3];
  logic         done  [3];
  logic         done_prev [3];

  logic [319:0] sbq [3][$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           lat_of [3] = '{9, 65, 2};

  logic [4:0] fwd_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  logic [4:0] inv_t [32] = '{5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
                             5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
                             5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
                             5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};

  always #5 clk = ~clk;

  inv_sbox_layer #(.LANES(8)) u_l8 (
    .clock_i(clk), .resetb_i(rstn), .start_i(start[0]), .state_i(sin[0]),
    .state_o(sout[0]), .busy_o(busy[0]), .done_o(done[0]));
  inv_sbox_layer #(.LANES(1)) u_l1 (
    .clock_i(clk), .resetb_i(rstn), .start_i(start[1]), .state_i(sin[1]),
    .state_o(sout[1]), .busy_o(busy[1]), .done_o(done[1]));
  inv_sbox_layer #(.LANES(64)) u_l64 (
    .clock_i(clk), .resetb_i(rstn), .start_i(start[2]), .state_i(sin[2]),
    .state_o(sout[2]), .busy_o(busy[2]), .done_o(done[2]));

  function automatic logic [4:0] get_col(input logic [319:0] s, input int j);
    return {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
  endfunction

  function automatic logic [319:0] set_col(input logic [319:0] s, input int j, input logic [4:0] v);
    logic [319:0] r;
    r = s;
    r[256+j] = v[4]; r[192+j] = v[3]; r[128+j] = v[2]; r[64+j] = v[1]; r[j] = v[0];
    return r;
  endfunction

  function automatic logic [319:0] fwd_state(input logic [319:0] s);
    logic [319:0] r;
    r = s;
    for (int j = 0; j < 64; j++) r = set_col(r, j, fwd_t[get_col(s, j)]);
    return r;
  endfunction

  function automatic logic [319:0] inv_state(input logic [319:0] s);
    logic [319:0] r;
    r = s;
    for (int j = 0; j < 64; j++) r = set_col(r, j, inv_t[get_col(s, j)]);
    return r;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int k, input logic [319:0] s, input logic [319:0] exp);
    start[k] = 1'b1;
    sin[k]   = s;
    sbq[k].push_back(exp);
  endtask

  // Step negedges until done of instance k; c counts negedges from the call point.
  task automatic wait_done(input int k, input bit drop, input int budget, output int c, output int bc);
    c  = 0;
    bc = 0;
    do begin
      @(negedge clk);
      c++;
      if (drop && c == 1) begin
        start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0;
      end
      if (busy[k]) bc++;
    end while (!done[k] && c < budget);
    if (!done[k]) begin
      n_chk++;
      n_fail++;
      $error("FAIL timeout_dut%0d observed=no_done expected=done_within_%0d", k, budget);
    end
  endtask

  // Scoreboard: every done pulse pops and compares, and must be one cycle wide.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rstn === 1'b1 && done[k] === 1'b1) begin
        chk($sformatf("done_width_dut%0d", k), 320'(done_prev[k]), 320'(0));
        if (sbq[k].size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL unexpected_done_dut%0d observed=done expected=no_done", k);
        end else begin
          chk($sformatf("result_dut%0d", k), sout[k], sbq[k].pop_front());
        end
      end
      done_prev[k] = done[k];
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] s, sp, a;
    int c, bc;

    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; sin[k] = '0; done_prev[k] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_state_dut%0d", k), sout[k], 320'(0));
      chk($sformatf("rst_busy_dut%0d", k), 320'(busy[k]), 320'(0));
      chk($sformatf("rst_done_dut%0d", k), 320'(done[k]), 320'(0));
    end
    rstn = 1'b1;
    @(negedge clk);

    // 1: all-zero state
    start_op(0, '0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});
    wait_done(0, 1'b1, 20, c, bc);
    chk("t1_latency", 320'(c), 320'(9));
    chk("t1_busy_cycles", 320'(bc), 320'(8));
    @(negedge clk);
    chk("t1_done_low_after", 320'(done[0]), 320'(0));

    // 2: every column value, twice
    s = '0;
    a = '0;
    for (int j = 0; j < 64; j++) begin
      s = set_col(s, j, 5'(j % 32));
      a = set_col(a, j, inv_t[j % 32]);
    end
    start_op(0, s, a);
    wait_done(0, 1'b1, 20, c, bc);
    chk("t2_latency", 320'(c), 320'(9));
    for (int j = 0; j < 64; j++)
      chk($sformatf("t2_col%0d", j), 320'(get_col(sout[0], j)), 320'(inv_t[j % 32]));
    @(negedge clk);

    // 3: forward-then-inverse round trip on LANES=8 and LANES=64 together
    for (int i = 0; i < 1000; i++) begin
      s  = rand320();
      sp = fwd_state(s);
      start_op(0, sp, s);
      start_op(2, sp, s);
      wait_done(0, 1'b1, 20, c, bc);
      chk("t3_latency_l8", 320'(c), 320'(lat_of[0]));
    end
    @(negedge clk);
    s = rand320();
    start_op(2, fwd_state(s), s);
    wait_done(2, 1'b1, 5, c, bc);
    chk("t3_latency_l64", 320'(c), 320'(lat_of[2]));
    @(negedge clk);
    // 3: round trip on LANES=1
    for (int i = 0; i < 250; i++) begin
      s = rand320();
      start_op(1, fwd_state(s), s);
      wait_done(1, 1'b1, 80, c, bc);
      chk("t3_latency_l1", 320'(c), 320'(lat_of[1]));
    end
    @(negedge clk);

    // 4: start pulse mid-RUN is ignored
    s = rand320();
    start_op(0, s, inv_state(s));
    @(negedge clk); start[0] = 1'b0;
    repeat (3) @(negedge clk);
    start[0] = 1'b1; sin[0] = rand320();
    @(negedge clk); start[0] = 1'b0;
    wait_done(0, 1'b0, 20, c, bc);
    chk("t4_latency", 320'(c), 320'(4));
    @(negedge clk);

    // 5: reset during chunk 3 aborts with no done
    s = rand320();
    start_op(0, s, inv_state(s));
    @(negedge clk); start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_state_zero", sout[0], 320'(0));
    chk("t5_busy_low", 320'(busy[0]), 320'(0));
    chk("t5_done_low", 320'(done[0]), 320'(0));
    sbq[0].delete();
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_still_idle", 320'(busy[0]), 320'(0));
    s = rand320();
    start_op(0, s, inv_state(s));
    wait_done(0, 1'b1, 20, c, bc);
    chk("t5_fresh_latency", 320'(c), 320'(9));
    @(negedge clk);

    // 6: start held through DONE gives back-to-back ops every N+1 cycles
    s = rand320();
    start_op(0, s, inv_state(s));
    wait_done(0, 1'b0, 20, c, bc);
    chk("t6_latency_first", 320'(c), 320'(9));
    s = rand320();
    start_op(0, s, inv_state(s));
    wait_done(0, 1'b0, 20, c, bc);
    chk("t6_period_1", 320'(c), 320'(9));
    chk("t6_busy_cycles", 320'(bc), 320'(8));
    s = rand320();
    a = inv_state(s);
    start_op(0, s, a);
    wait_done(0, 1'b1, 20, c, bc);
    chk("t6_period_2", 320'(c), 320'(9));
    repeat (5) @(negedge clk);
    chk("t6_idle_busy", 320'(busy[0]), 320'(0));
    chk("t6_idle_done", 320'(done[0]), 320'(0));
    chk("t6_held_result", sout[0], a);

    for (int k = 0; k < 3; k++)
      chk($sformatf("sb_empty_dut%0d", k), 320'(sbq[k].size()), 320'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
